// File: rtl/word_serial_pkg.sv
// Shared types and constants for the word-to-serial-bits converter.
package word_serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_W = 16;

endpackage

// File: rtl/serial_word_buffer.sv
// One-entry holding register with full flag; load wins data, load+drain stays full.
module serial_word_buffer
  import word_serial_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] hold_data,
  output logic         full
);

  logic [W-1:0] data_q, data_d;
  logic         full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = load_data;
      full_d = 1'b1;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign hold_data = data_q;
  assign full      = full_q;

endmodule

// File: rtl/word_to_serial_bits.sv
// Serializes W-bit words MSB first with frame_start/frame_last markers and
// a one-word holding register for zero-bubble back-to-back frames.
module word_to_serial_bits
  import word_serial_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         word_valid,
  input  logic [W-1:0] word_data,
  output logic         word_ready,
  input  logic         bit_ready,
  output logic         bit_valid,
  output logic         new_bit,
  output logic         frame_start,
  output logic         frame_last
);

  localparam int unsigned     CW       = $clog2(W);
  localparam logic [CW-1:0]   LAST_CNT = CW'(W - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_q, start_d;

  logic            hold_full;
  logic [W-1:0]    hold_data;
  logic            accept;
  logic            last_bit;
  logic            load_direct;
  logic            hold_load;
  logic            hold_drain;

  assign word_ready  = rst & ~hold_full;
  assign accept      = word_valid & word_ready;
  assign last_bit    = (state_q == SHIFT) & bit_ready & (cnt_q == LAST_CNT);
  // Direct load when idle, or when the frame ends with nothing held.
  assign load_direct = accept & ((state_q == IDLE) | (last_bit & ~hold_full));
  assign hold_load   = accept & ~load_direct;
  assign hold_drain  = last_bit & hold_full;

  serial_word_buffer #(.W(W)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .drain     (hold_drain),
    .load_data (word_data),
    .hold_data (hold_data),
    .full      (hold_full)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        if (load_direct) begin
          state_d = SHIFT;
          shift_d = word_data;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_ready) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (hold_full) begin
              shift_d = hold_data;
              start_d = 1'b1;
            end else if (load_direct) begin
              shift_d = word_data;
              start_d = 1'b1;
            end else begin
              state_d = IDLE;
              shift_d = '0;
              start_d = 1'b0;
            end
          end else begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
            start_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  assign bit_valid   = (state_q == SHIFT);
  assign new_bit     = shift_q[W-1];
  assign frame_start = start_q;
  assign frame_last  = (cnt_q == LAST_CNT);

endmodule

// File: doc/word_to_serial_bits.md
WORD_TO_SERIAL_BITS -- requirements
Module: word_to_serial_bits

Interface
REQ-001 Parameter W SHALL be: default 16; word width in bits; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the reset; synchronous, active-low (asserted when rst = 0).
REQ-004 word_valid  input  1  SHALL indicate that word_data holds a word to serialize.
REQ-005 word_data  input  W  SHALL be the word; bits are emitted MSB first.
REQ-006 word_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-007 bit_ready  input  1  SHALL be the downstream advance/stall control; 1 = consume the current bit.
REQ-008 bit_valid  output  1  SHALL indicate that new_bit carries a frame bit.
REQ-009 new_bit  output  1  SHALL be the current serial bit, to the downstream serial divisibility checker.
REQ-010 frame_start  output  1  SHALL be high with the first bit (MSB) of each frame; the downstream block uses it to clear its remainder.
REQ-011 frame_last  output  1  SHALL be high with the last bit (LSB) of each frame.

Function
REQ-012 A word SHALL be accepted on a rising edge where word_valid && word_ready.
REQ-013 word_ready SHALL equal !hold_full (a one-word holding register); it SHALL NOT depend combinationally on bit_ready.
REQ-014 FSM states SHALL be IDLE (bit_valid = 0) and SHIFT (bit_valid = 1).
REQ-015 IDLE: an accepted word SHALL load the shifter directly, bypassing the holding register; the next cycle SHALL be SHIFT with frame_start = 1 and new_bit = word_data[W-1] (latency 1 cycle).
REQ-016 SHIFT with bit_ready = 0: new_bit, bit_valid, frame_start, frame_last and the bit counter SHALL hold unchanged.
REQ-017 SHIFT with bit_ready = 1, not last bit: shift one position, counter +1, frame_start = 0.
REQ-018 frame_last SHALL be 1 exactly when the counter = W-1.
REQ-019 Last bit consumed with the holding register full: the holding word SHALL move to the shifter and the FSM SHALL stay in SHIFT with frame_start = 1 next cycle (zero-bubble back-to-back frames).
REQ-020 Last bit consumed with the holding register empty and a word accepted the same cycle: the accepted word SHALL load the shifter directly, giving zero bubble.
REQ-021 Last bit consumed with no word available: the FSM SHALL go to IDLE.
REQ-022 In SHIFT, an accepted word SHALL go to the holding register, unless REQ-020 applies.
REQ-023 The counter SHALL be $clog2(W) bits and SHALL wrap to 0 on every frame load.
REQ-024 The outputs SHALL be registered, with no combinational path from word_data to new_bit.

Reset
REQ-025 While rst = 0, on each posedge: state = IDLE, hold_full = 0, counter = 0, shifter = 0, bit_valid = 0, new_bit = 0, frame_start = 0, frame_last = 0; word_ready SHALL read 0 during reset.
REQ-026 Reset mid-frame SHALL discard the partial frame and the held word; no frame_last SHALL be emitted for it.
REQ-027 The first cycle after rst returns to 1 SHALL have word_ready = 1, and words SHALL be accepted normally.

Structure
REQ-028 Package word_serial_pkg SHALL hold the state enum (IDLE, SHIFT) and the default width constant 16.
REQ-029 The holding register SHALL be a sub-module, serial_word_buffer: one-entry register with full flag, load, drain and simultaneous load+drain.
REQ-030 The FSM, shifter and counter SHALL reside in the top module; the top module SHALL contain no other sub-modules.

Verification
REQ-031 W=16, bit_ready=1, single word 0x000F -> bits 0000000000001111 on 16 consecutive cycles, starting 1 cycle after accept; frame_start on cycle 1 only, frame_last on cycle 16 only; then IDLE.
REQ-032 Words 0xA5A5 and 0x0005 offered back-to-back -> 32 consecutive valid bits with no gap; frame_start on bits 1 and 17; chained divisibility-by-5 checker flags 1 after bit 32.
REQ-033 Three words offered while the first is shifting -> second held, word_ready = 0 until the second loads into the shifter at the end of frame 1; third accepted on the next word_ready = 1 cycle.
REQ-034 Word 0x8001 with bit_ready toggled 1,0,0,1,... -> each bit held while stalled; sequence unchanged; frame_last after exactly 16 consumed bits.
REQ-035 rst = 0 asserted after 7 bits of 0xFFFF with one word held -> all outputs 0 next edge, no further bits; after release, new word 0x0003 serializes correctly from frame_start.
REQ-036 Randomized 1000 words, random word_valid and bit_ready -> reassembled words match the input order exactly; frame_start count = frame_last count = accepted word count.
